calculator_core: RTL and testbench
==================================

# calculator_core

Four-digit decimal calculator for the board's 7-segment display. Operands A and B are dialled digit by digit with four sliders and confirmed with an Enter button. An arithmetic slider selects add or subtract, and a Clear button resets the calculation. The block sits at the top of the board design and drives the multiplexed 4-digit common-anode display directly from raw, undebounced switch inputs.

## Interface
- `REFRESH_OVERFLOW`, default 100000: clock cycles each display digit stays selected.
- `DB_OVERFLOW`, default 500000: consecutive cycles a synchronized button level must differ from its debounced state before that state flips; must be ≥1.
- `SLIDER_OVERFLOW`, default 25000000: auto-repeat period, in cycles, while a digit slider is held; must be ≥1.
- `clk` in 1: single system clock; all state on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `button_clr_undeb` in 1: raw Clear button, active high.
- `button_ent_undeb` in 1: raw Enter button, active high.
- `sld_1`, `sld_2`, `sld_3`, `sld_4` in 1 each: digit sliders for ones, tens, hundreds and thousands.
- `sld_arith` in 1: operation toggle slider.
- `digit_select` out 4: active-low one-hot digit enable; bit 0 is the rightmost (ones) digit.
- `led_select` out 7: active-low segments; bit 0 = a … bit 6 = g.

## Operation
- **Input conditioning**
  - Every input passes through a 2-flop synchronizer.
  - Buttons are then debounced and produce a 1-cycle pulse on the rising edge of the debounced level.
  - Sliders are not debounced.
- **States:** ENTER_A → ENTER_B → SELECT_OP → RESULT → ENTER_A.
  - Each transition happens on an Enter pulse.
  - RESULT → ENTER_A also zeroes A, B and the result.
- **Digit entry (ENTER_A / ENTER_B)**
  - A slider rising edge increments its digit of the current operand immediately.
  - While the slider stays high, the digit increments again every SLIDER_OVERFLOW cycles.
  - Digits are BCD and wrap 9→0 without carrying into the next digit.
  - Several sliders high at once each act independently.
  - Sliders are ignored in SELECT_OP and RESULT.
- **Operation select**
  - Operation register defaults to ADD.
  - In SELECT_OP only, each synchronized rising edge of `sld_arith` toggles ADD/SUB.
- **Result**
  - Computed on entry to RESULT using BCD arithmetic modulo 10000.
  - ADD: (A+B) mod 10000.
  - SUB: (A−B) mod 10000, i.e. ten's complement; negative results are not flagged.
- **Display**
  - ENTER_A shows A, ENTER_B shows B, RESULT shows the result.
  - SELECT_OP shows "Add " or "Sub " (A, d, d, blank / S, u, b, blank; thousands digit leftmost).
  - Decimal digits use the standard 0–9 patterns.
- **Clear:** a Clear pulse in any state → ENTER_A, with A, B and the result zeroed and the operation set to ADD.
- **Simultaneous pulses:** Clear wins over Enter in the same cycle.

## Timing
- **Reset values**
  - State ENTER_A; all operands 0; operation ADD; all counters 0.
  - `digit_select` = 4'b1110.
  - `led_select` = 7'b1000000, the glyph "0".
- **Button latency**
  - Raw edge → 2 synchronizer cycles → DB_OVERFLOW cycles of stable level → pulse.
  - The state or register update is visible on the following cycle.
  - A raw pulse shorter than DB_OVERFLOW cycles at the synchronizer output is rejected.
- **Slider latency**
  - Increment lands 3 cycles after the raw rising edge.
  - Holding a slider for N synchronized cycles yields ceil(N / SLIDER_OVERFLOW) increments.
- **Display refresh**
  - The digit advances 0→1→2→3→0 every REFRESH_OVERFLOW cycles.
  - `digit_select` and `led_select` are registered and change in the same cycle; there is no ghosting cycle.
- **Reset assertion** at any time forces reset values immediately, without waiting for a clock edge.

## Configuration
- `CALC_LEADING_ZERO_BLANK_EN`
  - Defined: in numeric displays, leading zero digits are blanked (all segments off); the ones digit always shows.
  - Undefined: all four digits are always shown, e.g. "0042".

## Test plan
All scenarios use REFRESH_OVERFLOW=10, DB_OVERFLOW=1 and SLIDER_OVERFLOW=3.
- Release reset, then hold `sld_1`, `sld_2`, `sld_3`, `sld_4` high for 2, 8, 4 and 12 cycles respectively → A = 4231. Press Enter for 1 cycle → state ENTER_B.
- Hold the sliders for 6, 15, 4 and 20 cycles → B = 7252. Press Enter → SELECT_OP, display shows "Add ". Press Enter → result 1483.
- Repeat with one `sld_arith` pulse in SELECT_OP → display shows "Sub ". Press Enter → result 6979.
- Hold `sld_1` for 31 cycles from 0 → ones digit 1, after 11 increments and one 9→0 wrap. The tens digit is unchanged.
- In RESULT, raise `sld_4` for 12 cycles → result unchanged. Press Clear → ENTER_A, display "0000", or blank-blank-blank-0 with `CALC_LEADING_ZERO_BLANK_EN`.
- Check `digit_select` cycles 1110, 1101, 1011, 0111 with a 10-cycle dwell each. Assert reset mid-scan → outputs return immediately to 1110 / 1000000.

Source files
------------

// File: rtl/calculator_core.sv
// calculator_core: four-digit BCD add/subtract calculator driving a
// multiplexed common-anode 7-segment display from raw switch inputs.
// Optional build macro CALC_LEADING_ZERO_BLANK_EN blanks leading zeros.
module calculator_core #(
    parameter int unsigned REFRESH_OVERFLOW = 100000,
    parameter int unsigned DB_OVERFLOW      = 500000,
    parameter int unsigned SLIDER_OVERFLOW  = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_clr_undeb,
    input  logic       button_ent_undeb,
    input  logic       sld_1,
    input  logic       sld_2,
    input  logic       sld_3,
    input  logic       sld_4,
    input  logic       sld_arith,
    output logic [3:0] digit_select,
    output logic [6:0] led_select
);

    localparam int unsigned REF_W = $clog2(REFRESH_OVERFLOW + 1);
    localparam int unsigned DB_W  = $clog2(DB_OVERFLOW + 1);
    localparam int unsigned SLD_W = $clog2(SLIDER_OVERFLOW + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_U     = 7'b1100011;
    localparam logic [6:0] SEG_B     = 7'b0000011;

    typedef enum logic [1:0] {ENTER_A, ENTER_B, SELECT_OP, RESULT} state_t;

    // Input bit order: 0 clr, 1 ent, 2..5 sld_1..sld_4, 6 arith
    logic [6:0]       sync1, sync2;
    logic [1:0]       db_q, db_prev;
    logic [DB_W-1:0]  db_cnt [2];
    logic [3:0]       sld_prev;
    logic [SLD_W-1:0] rep_cnt [4];
    logic [3:0]       inc;
    logic             arith_prev;
    logic             clr_pulse, ent_pulse, arith_rise;

    state_t           state_q, state_d;
    logic [15:0]      a_q, b_q, res_q, bcd_res;
    logic             op_sub;

    logic [REF_W-1:0] ref_cnt;
    logic [1:0]       dig_idx;
    logic [15:0]      disp_val;
    logic [6:0]       glyph;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Per-digit BCD increment with 9->0 wrap and no carry between digits
    function automatic logic [15:0] bump(input logic [15:0] v, input logic [3:0] m);
        bump = v;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                bump[4*i +: 4] = (v[4*i +: 4] == 4'd9) ? 4'd0 : 4'(v[4*i +: 4] + 4'd1);
            end
        end
    endfunction

    // Two-flop synchronizers for every raw input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sld_arith, sld_4, sld_3, sld_2, sld_1, button_ent_undeb, button_clr_undeb};
            sync2 <= sync1;
        end
    end

    // Button debounce: flip after DB_OVERFLOW consecutive differing cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_q    <= '0;
            db_prev <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            db_prev <= db_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != db_q[i]) begin
                    if (db_cnt[i] == DB_W'(DB_OVERFLOW - 1)) begin
                        db_q[i]   <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign clr_pulse  = db_q[0] & ~db_prev[0];
    assign ent_pulse  = db_q[1] & ~db_prev[1];
    assign arith_rise = sync2[6] & ~arith_prev;

    // Slider increment request: on the rising edge, then every SLIDER_OVERFLOW held cycles
    always_comb begin
        inc = '0;
        for (int i = 0; i < 4; i++) begin
            inc[i] = sync2[i+2] & (~sld_prev[i] | (rep_cnt[i] == SLD_W'(SLIDER_OVERFLOW)));
        end
    end

    // Slider edge history and auto-repeat counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sld_prev   <= '0;
            arith_prev <= 1'b0;
            for (int i = 0; i < 4; i++) rep_cnt[i] <= '0;
        end else begin
            sld_prev   <= sync2[5:2];
            arith_prev <= sync2[6];
            for (int i = 0; i < 4; i++) begin
                if (!sync2[i+2])  rep_cnt[i] <= '0;
                else if (inc[i])  rep_cnt[i] <= SLD_W'(1);
                else              rep_cnt[i] <= rep_cnt[i] + SLD_W'(1);
            end
        end
    end

    // Digit-serial BCD add, or ten's-complement subtract, modulo 10000
    always_comb begin
        logic       carry;
        logic [3:0] bd;
        logic [4:0] sum;
        carry   = op_sub;
        bd      = '0;
        sum     = '0;
        bcd_res = '0;
        for (int i = 0; i < 4; i++) begin
            bd  = op_sub ? 4'(4'd9 - b_q[4*i +: 4]) : b_q[4*i +: 4];
            sum = 5'(a_q[4*i +: 4]) + 5'(bd) + 5'(carry);
            if (sum >= 5'd10) begin
                sum   = sum - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            bcd_res[4*i +: 4] = sum[3:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ENTER_A;
        else        state_q <= state_d;
    end

    // Next state: Clear dominates Enter
    always_comb begin
        state_d = state_q;
        if (clr_pulse) begin
            state_d = ENTER_A;
        end else if (ent_pulse) begin
            case (state_q)
                ENTER_A:   state_d = ENTER_B;
                ENTER_B:   state_d = SELECT_OP;
                SELECT_OP: state_d = RESULT;
                default:   state_d = ENTER_A;
            endcase
        end
    end

    // Operands, result and operation registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            op_sub <= 1'b0;
        end else if (clr_pulse) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            op_sub <= 1'b0;
        end else if (ent_pulse && state_q == RESULT) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else begin
            if (state_q == ENTER_A) a_q <= bump(a_q, inc);
            if (state_q == ENTER_B) b_q <= bump(b_q, inc);
            if (state_q == SELECT_OP && arith_rise) op_sub <= ~op_sub;
            if (state_q == SELECT_OP && ent_pulse)  res_q  <= bcd_res;
        end
    end

    // Refresh timer and active digit index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_cnt <= '0;
            dig_idx <= '0;
        end else if (ref_cnt == REF_W'(REFRESH_OVERFLOW - 1)) begin
            ref_cnt <= '0;
            dig_idx <= dig_idx + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
        end
    end

`ifdef CALC_LEADING_ZERO_BLANK_EN
    logic [3:0] lz;
    // Digits above the highest non-zero digit are blank; ones never blanks
    assign lz[3] = (disp_val[15:12] == 4'd0);
    assign lz[2] = lz[3] & (disp_val[11:8] == 4'd0);
    assign lz[1] = lz[2] & (disp_val[7:4] == 4'd0);
    assign lz[0] = 1'b0;
`endif

    // Glyph for the currently selected digit
    always_comb begin
        case (state_q)
            ENTER_B: disp_val = b_q;
            RESULT:  disp_val = res_q;
            default: disp_val = a_q;
        endcase
        glyph = seg7(disp_val[{dig_idx, 2'b00} +: 4]);
`ifdef CALC_LEADING_ZERO_BLANK_EN
        if (lz[dig_idx]) glyph = SEG_BLANK;
`endif
        if (state_q == SELECT_OP) begin
            case (dig_idx)
                2'd3:    glyph = op_sub ? SEG_S : SEG_A;
                2'd2:    glyph = op_sub ? SEG_U : SEG_D;
                2'd1:    glyph = op_sub ? SEG_B : SEG_D;
                default: glyph = SEG_BLANK;
            endcase
        end
    end

    // Registered display drive; enable and segments update together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_select <= 4'b1110;
            led_select   <= 7'b1000000;
        end else begin
            digit_select <= ~(4'b0001 << dig_idx);
            led_select   <= glyph;
        end
    end

endmodule

// File: tb/tb_calculator_core.sv
// Randomized self-checking bench for calculator_core with a behavioural
// decimal reference model; honours CALC_LEADING_ZERO_BLANK_EN.
module tb_calculator_core;

    localparam int unsigned REF = 10;
    localparam int unsigned DB  = 1;
    localparam int unsigned SLD = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       button_clr_undeb = 1'b0;
    logic       button_ent_undeb = 1'b0;
    logic       sld_1 = 1'b0, sld_2 = 1'b0, sld_3 = 1'b0, sld_4 = 1'b0;
    logic       sld_arith = 1'b0;
    logic [3:0] digit_select;
    logic [6:0] led_select;

    calculator_core #(
        .REFRESH_OVERFLOW(REF),
        .DB_OVERFLOW(DB),
        .SLIDER_OVERFLOW(SLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .button_clr_undeb(button_clr_undeb),
        .button_ent_undeb(button_ent_undeb),
        .sld_1(sld_1),
        .sld_2(sld_2),
        .sld_3(sld_3),
        .sld_4(sld_4),
        .sld_arith(sld_arith),
        .digit_select(digit_select),
        .led_select(led_select)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: operands as decimal digit arrays, state as 0..3
    int a_m [4];
    int b_m [4];
    int res_m;
    bit sub_m;
    int st_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'b1000000;  1: seg = 7'b1111001;
            2: seg = 7'b0100100;  3: seg = 7'b0110000;
            4: seg = 7'b0011001;  5: seg = 7'b0010010;
            6: seg = 7'b0000010;  7: seg = 7'b1111000;
            8: seg = 7'b0000000;  9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    function automatic int val_a();
        return a_m[3]*1000 + a_m[2]*100 + a_m[1]*10 + a_m[0];
    endfunction

    function automatic int val_b();
        return b_m[3]*1000 + b_m[2]*100 + b_m[1]*10 + b_m[0];
    endfunction

    function automatic logic [27:0] num_glyph(input int v);
        int p [4] = '{1, 10, 100, 1000};
        logic [27:0] g;
        for (int i = 0; i < 4; i++) begin
            g[7*i +: 7] = seg((v / p[i]) % 10);
`ifdef CALC_LEADING_ZERO_BLANK_EN
            if (i > 0 && v < p[i]) g[7*i +: 7] = 7'b1111111;
`endif
        end
        return g;
    endfunction

    function automatic logic [27:0] exp_glyph();
        case (st_m)
            0: return num_glyph(val_a());
            1: return num_glyph(val_b());
            2: return sub_m ? {7'b0010010, 7'b1100011, 7'b0000011, 7'b1111111}
                            : {7'b0001000, 7'b0100001, 7'b0100001, 7'b1111111};
            default: return num_glyph(res_m);
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin a_m[i] = 0; b_m[i] = 0; end
        res_m = 0; sub_m = 0; st_m = 0;
    endtask

    // Scan the display for one full refresh round; unseen digits stay X
    task automatic read_display(output logic [27:0] g);
        bit [3:0] seen = '0;
        g = 'x;
        for (int k = 0; k < 120 && seen != 4'hF; k++) begin
            @(negedge clk);
            case (digit_select)
                4'b1110: begin g[6:0]   = led_select; seen[0] = 1'b1; end
                4'b1101: begin g[13:7]  = led_select; seen[1] = 1'b1; end
                4'b1011: begin g[20:14] = led_select; seen[2] = 1'b1; end
                4'b0111: begin g[27:21] = led_select; seen[3] = 1'b1; end
                default: ;
            endcase
        end
    endtask

    task automatic check_display(input string tag);
        logic [27:0] g;
        read_display(g);
        check(tag, {4'b0, g}, {4'b0, exp_glyph()});
    endtask

    task automatic hold_sliders(input logic [3:0] mask, input int n);
        @(negedge clk);
        {sld_4, sld_3, sld_2, sld_1} = mask;
        repeat (n) @(negedge clk);
        {sld_4, sld_3, sld_2, sld_1} = 4'b0000;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                if (st_m == 0) a_m[i] = (a_m[i] + (n + SLD - 1) / SLD) % 10;
                if (st_m == 1) b_m[i] = (b_m[i] + (n + SLD - 1) / SLD) % 10;
            end
        end
    endtask

    task automatic press(input bit ent, input bit clr);
        @(negedge clk);
        button_ent_undeb = ent;
        button_clr_undeb = clr;
        @(negedge clk);
        button_ent_undeb = 1'b0;
        button_clr_undeb = 1'b0;
        repeat (6) @(negedge clk);
        if (clr) begin
            model_clear();
        end else if (ent) begin
            case (st_m)
                0: st_m = 1;
                1: st_m = 2;
                2: begin
                    res_m = sub_m ? (val_a() - val_b() + 10000) % 10000
                                  : (val_a() + val_b()) % 10000;
                    st_m = 3;
                end
                default: begin
                    for (int i = 0; i < 4; i++) begin a_m[i] = 0; b_m[i] = 0; end
                    res_m = 0;
                    st_m = 0;
                end
            endcase
        end
    endtask

    task automatic arith_pulse();
        @(negedge clk);
        sld_arith = 1'b1;
        repeat (2) @(negedge clk);
        sld_arith = 1'b0;
        repeat (4) @(negedge clk);
        if (st_m == 2) sub_m = ~sub_m;
    endtask

    task automatic enter_operand(input int n1, input int n2, input int n3, input int n4);
        hold_sliders(4'b0001, n1);
        hold_sliders(4'b0010, n2);
        hold_sliders(4'b0100, n3);
        hold_sliders(4'b1000, n4);
    endtask

    initial begin
        logic [3:0] pats [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] prev;
        bit         found;
        int         cnt;

        model_clear();
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_digit_select", {28'b0, digit_select}, 32'h0000_000E);
        check("reset_led_select", {25'b0, led_select}, 32'h0000_0040);
        reset = 1'b1;
        check_display("reset_display");

        // Directed add and subtract sequences
        enter_operand(2, 8, 4, 12);
        check_display("a_4231");
        press(1, 0);
        check_display("enter_b_blank_operand");
        enter_operand(6, 15, 4, 20);
        check_display("b_7252");
        press(1, 0);
        check_display("select_add");
        press(1, 0);
        check_display("result_add_1483");
        hold_sliders(4'b1000, 12);
        check_display("result_ignores_slider");
        press(0, 1);
        check_display("clear_to_zero");

        enter_operand(2, 8, 4, 12);
        press(1, 0);
        enter_operand(6, 15, 4, 20);
        press(1, 0);
        arith_pulse();
        check_display("select_sub");
        press(1, 0);
        check_display("result_sub_6979");
        press(1, 0);
        check_display("result_to_enter_a");

        // Ones wraps past 9 without touching tens
        hold_sliders(4'b0010, 4);
        hold_sliders(4'b0001, 31);
        check_display("ones_wrap_0021");

        // Clear beats a simultaneous Enter
        press(1, 0);
        hold_sliders(4'b0001, 7);
        check_display("b_before_dual_press");
        press(1, 1);
        check_display("clear_beats_enter");

        // Randomized full calculations, including simultaneous sliders
        for (int it = 0; it < 6; it++) begin
            for (int op = 0; op < 2; op++) begin
                for (int s = 0; s < 3; s++) begin
                    hold_sliders(4'($urandom_range(1, 15)), int'($urandom_range(1, 20)));
                end
                if ($urandom_range(0, 1) == 1) arith_pulse();
                check_display($sformatf("rand%0d_operand%0d", it, op));
                press(1, 0);
            end
            check_display($sformatf("rand%0d_select", it));
            for (int t = $urandom_range(0, 3); t > 0; t--) arith_pulse();
            check_display($sformatf("rand%0d_select_after_toggle", it));
            press(1, 0);
            check_display($sformatf("rand%0d_result", it));
            press(1, 0);
            check_display($sformatf("rand%0d_back_to_a", it));
        end

        // Refresh scan order and dwell
        found = 1'b0;
        prev  = digit_select;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (prev == 4'b0111 && digit_select == 4'b1110) found = 1'b1;
            prev = digit_select;
        end
        check("scan_sync", {31'b0, found}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            while (digit_select == pats[k] && cnt < 50) begin
                cnt++;
                @(negedge clk);
            end
            check($sformatf("scan_dwell%0d", k), cnt, 32'(REF));
        end

        // Asynchronous reset mid-scan
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (digit_select == 4'b1011) found = 1'b1;
        end
        check("reset_scan_sync", {31'b0, found}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_digit_select", {28'b0, digit_select}, 32'h0000_000E);
        check("async_reset_led_select", {25'b0, led_select}, 32'h0000_0040);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        check_display("post_reset_display");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
